// File: rtl/ifid_pipe.sv
// IF/ID pipeline register: captures the fetched instruction and its PCs,
// with flush-to-bubble, stall hold, halt freeze and saturating event counters.
module ifid_pipe #(
    parameter logic [3:0]  HALT_OPCODE  = 4'hF,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [15:0] instr_IF,
    input  logic [15:0] PC_IF,
    input  logic [15:0] PC_plus2_IF,
    output logic [15:0] instr_ID,
    output logic [15:0] PC_ID,
    output logic [15:0] PC_plus2_ID,
    output logic        valid_ID,
    output logic        halt_ID,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned W      = 16;
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] instr_q,    instr_d;
    logic [W-1:0] pc_q,       pc_d;
    logic [W-1:0] pc2_q,      pc2_d;
    logic         valid_q,    valid_d;
    logic         halt_q,     halt_d;
    logic [W-1:0] stall_cnt_q, stall_cnt_d;
    logic [W-1:0] flush_cnt_q, flush_cnt_d;

    // Next-state selection in priority order: flush, halt freeze, stall, capture.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc2_d       = pc2_q;
        valid_d     = valid_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            // A flush during halt means the halt was on a wrong path; drop it.
            instr_d = BUBBLE_INSTR;
            pc_d    = '0;
            pc2_d   = '0;
            valid_d = 1'b0;
            halt_d  = 1'b0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + W'(1);
            end
        end else if (halt_q) begin
            // Halt freeze: everything holds regardless of en.
            halt_d = 1'b1;
        end else if (!en) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + W'(1);
            end
        end else begin
            instr_d = instr_IF;
            pc_d    = PC_IF;
            pc2_d   = PC_plus2_IF;
            valid_d = 1'b1;
            halt_d  = (instr_IF[OP_MSB:OP_LSB] == HALT_OPCODE);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= BUBBLE_INSTR;
            pc_q        <= '0;
            pc2_q       <= '0;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc2_q       <= pc2_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign instr_ID    = instr_q;
    assign PC_ID       = pc_q;
    assign PC_plus2_ID = pc2_q;
    assign valid_ID    = valid_q;
    assign halt_ID     = halt_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_ifid_pipe.sv
// Directed scoreboard bench for ifid_pipe.
module tb_ifid_pipe;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        valid;
        logic        halt;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_IF = '0;
    logic [15:0] PC_IF = '0;
    logic [15:0] PC_plus2_IF = '0;
    logic [15:0] instr_ID, PC_ID, PC_plus2_ID, stall_cnt, flush_cnt;
    logic        valid_ID, halt_ID;

    int errors = 0;
    int checks = 0;

    exp_t mdl;
    exp_t sb_q[$];

    ifid_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .instr_IF    (instr_IF),
        .PC_IF       (PC_IF),
        .PC_plus2_IF (PC_plus2_IF),
        .instr_ID    (instr_ID),
        .PC_ID       (PC_ID),
        .PC_plus2_ID (PC_plus2_ID),
        .valid_ID    (valid_ID),
        .halt_ID     (halt_ID),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Behavioural reference: reset > flush > halt freeze > stall > capture.
    task automatic model_step(input logic r, input logic e, input logic f,
                              input logic [15:0] i, input logic [15:0] p, input logic [15:0] p2);
        if (r) begin
            mdl = '0;
        end else if (f) begin
            mdl.instr = 16'h0000; mdl.pc = '0; mdl.pc2 = '0;
            mdl.valid = 1'b0; mdl.halt = 1'b0;
            mdl.fc = (mdl.fc == 16'hFFFF) ? 16'hFFFF : mdl.fc + 16'd1;
        end else if (mdl.halt) begin
            // frozen
        end else if (!e) begin
            mdl.sc = (mdl.sc == 16'hFFFF) ? 16'hFFFF : mdl.sc + 16'd1;
        end else begin
            mdl.instr = i; mdl.pc = p; mdl.pc2 = p2; mdl.valid = 1'b1;
            mdl.halt = (i[15:12] == 4'hF);
        end
    endtask

    // One clock: drive at negedge, push expectation, compare after the edge.
    task automatic step(input logic r, input logic e, input logic f,
                        input logic [15:0] i, input logic [15:0] p, input logic [15:0] p2);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; flush = f; instr_IF = i; PC_IF = p; PC_plus2_IF = p2;
        model_step(r, e, f, i, p, p2);
        sb_q.push_back(mdl);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check("sb_instr", instr_ID, x.instr);
        check("sb_pc", PC_ID, x.pc);
        check("sb_pc2", PC_plus2_ID, x.pc2);
        check("sb_valid", 16'(valid_ID), 16'(x.valid));
        check("sb_halt", 16'(halt_ID), 16'(x.halt));
        check("sb_stall", stall_cnt, x.sc);
        check("sb_flush", flush_cnt, x.fc);
    endtask

    initial begin
        mdl = '0;

        // Reset
        step(1, 0, 0, 16'hDEAD, 16'hBEEF, 16'hCAFE);
        check("rst_instr", instr_ID, 16'h0000);
        check("rst_valid", 16'(valid_ID), 16'd0);

        // Capture
        step(0, 1, 0, 16'h1234, 16'h0010, 16'h0012);
        check("cap_instr", instr_ID, 16'h1234);
        check("cap_pc", PC_ID, 16'h0010);
        check("cap_pc2", PC_plus2_ID, 16'h0012);
        check("cap_valid", 16'(valid_ID), 16'd1);
        check("cap_halt", 16'(halt_ID), 16'd0);

        // Stall three cycles with changing inputs
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 16'(16'h4000 + k), 16'(16'h0100 + k), 16'(16'h0102 + k));
        end
        check("stall_instr", instr_ID, 16'h1234);
        check("stall_pc", PC_ID, 16'h0010);
        check("stall_cnt3", stall_cnt, 16'd3);

        // Flush beats stall
        step(0, 0, 1, 16'h5555, 16'h0200, 16'h0202);
        check("fl_instr", instr_ID, 16'h0000);
        check("fl_valid", 16'(valid_ID), 16'd0);
        check("fl_fcnt", flush_cnt, 16'd1);
        check("fl_scnt", stall_cnt, 16'd3);

        // Halt freeze
        step(0, 1, 0, 16'hF000, 16'h0020, 16'h0022);
        check("halt_set", 16'(halt_ID), 16'd1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 16'h2222, 16'h0030, 16'h0032);
        end
        step(0, 0, 0, 16'h2222, 16'h0030, 16'h0032);
        check("halt_hold_instr", instr_ID, 16'hF000);
        check("halt_hold_pc", PC_ID, 16'h0020);
        check("halt_scnt", stall_cnt, 16'd3);
        step(0, 0, 1, 16'h2222, 16'h0030, 16'h0032);
        check("halt_fl_halt", 16'(halt_ID), 16'd0);
        check("halt_fl_valid", 16'(valid_ID), 16'd0);
        check("halt_fl_fcnt", flush_cnt, 16'd2);
        step(0, 1, 0, 16'h5678, 16'h0040, 16'h0042);
        check("post_halt_cap", instr_ID, 16'h5678);

        // Reset mid-halt with stall_cnt=7
        step(1, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 16'h1111, 16'h0050, 16'h0052);
        end
        step(0, 1, 0, 16'hF001, 16'h0060, 16'h0062);
        check("mh_halt", 16'(halt_ID), 16'd1);
        check("mh_scnt", stall_cnt, 16'd7);
        step(1, 1, 0, 16'h7777, 16'h0070, 16'h0072);
        check("mh_rst_instr", instr_ID, 16'h0000);
        check("mh_rst_halt", 16'(halt_ID), 16'd0);
        check("mh_rst_scnt", stall_cnt, 16'd0);
        step(0, 1, 0, 16'hABCD, 16'h0080, 16'h0082);
        check("mh_new_cap", instr_ID, 16'hABCD);
        check("mh_new_valid", 16'(valid_ID), 16'd1);

        // Reset beats flush; held reset stays at reset values
        step(1, 1, 1, 16'h9999, 16'h0090, 16'h0092);
        step(1, 0, 1, 16'h9999, 16'h0090, 16'h0092);
        check("rstfl_fcnt", flush_cnt, 16'd0);
        check("rstfl_pc2", PC_plus2_ID, 16'd0);

        // Stall counter saturation
        step(0, 1, 0, 16'h3333, 16'h00A0, 16'h00A2);
        for (int k = 0; k < 65540; k++) begin
            step(0, 0, 0, 16'(k), 16'h00B0, 16'h00B2);
        end
        check("sat_scnt", stall_cnt, 16'hFFFF);
        check("sat_instr", instr_ID, 16'h3333);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        check("sat_nowrap", stall_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
